// File: rtl/test_supervisor_pkg.sv
// Shared definitions for the riscv-tests run supervisor: FSM state encoding
// and tohost field positions.
package test_supervisor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESET,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int unsigned TOHOST_DONE_BIT    = 0;
    localparam int unsigned TOHOST_TESTNUM_LSB = 1;

endpackage

// File: rtl/test_supervisor_hart_result_latch.sv
// Per-hart tohost result capture: first write with the done bit set is latched,
// later writes are ignored until cleared.
module hart_result_latch
    import test_supervisor_pkg::*;
#(
    parameter int unsigned      XLEN       = 32,
    parameter logic [XLEN-1:0]  PASS_VALUE = XLEN'(1)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_en,
    input  logic            i_clear,
    input  logic            i_vld,
    input  logic [XLEN-1:0] i_data,
    output logic            o_reported,
    output logic            o_passed,
    output logic [XLEN-2:0] o_testnum
);

    logic            r_reported;
    logic [XLEN-1:0] r_value;
    logic            w_capture;
    logic [XLEN-1:0] w_value;

    assign w_capture = i_en && i_vld && i_data[TOHOST_DONE_BIT] && !r_reported;

    // Outputs look through the capturing write so completion is seen in the same cycle.
    assign w_value    = w_capture ? i_data : r_value;
    assign o_reported = r_reported || w_capture;
    assign o_passed   = o_reported && (w_value == PASS_VALUE);
    assign o_testnum  = w_value[XLEN-1:TOHOST_TESTNUM_LSB];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_reported <= 1'b0;
            r_value    <= '0;
        end else if (i_clear) begin
            r_reported <= 1'b0;
            r_value    <= '0;
        end else if (w_capture) begin
            r_reported <= 1'b1;
            r_value    <= i_data;
        end
    end

endmodule

// File: rtl/test_supervisor.sv
// riscv-tests run controller: core reset sequencing, per-hart tohost capture and timeout.
// Optional TEST_SUPERVISOR_GP_FALLBACK_EN judges unreported harts by gp_value on timeout.
module test_supervisor
    import test_supervisor_pkg::*;
#(
    parameter int unsigned      XLEN           = 32,
    parameter int unsigned      NUM_HARTS      = 1,
    parameter int unsigned      RESET_CYCLES   = 2,
    parameter int unsigned      TIMEOUT_CYCLES = 5000,
    parameter logic [XLEN-1:0]  PASS_VALUE     = XLEN'(1),
    localparam int unsigned     HW             = $clog2((NUM_HARTS > 2) ? NUM_HARTS : 2),
    localparam int unsigned     CW             = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      core_rst,
    input  logic [NUM_HARTS-1:0]      tohost_vld,
    input  logic [NUM_HARTS*XLEN-1:0] tohost_data,
    input  logic [NUM_HARTS*XLEN-1:0] gp_value,
    output logic                      running,
    output logic                      done,
    output logic                      pass,
    output logic                      timeout,
    output logic [HW-1:0]             fail_hart,
    output logic [XLEN-2:0]           fail_testnum,
    output logic [CW-1:0]             cycle_count
);

    localparam int unsigned RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    state_t                r_state;
    logic [RCW-1:0]        r_rst_cnt;
    logic                  w_run;
    logic                  w_clear;
    logic                  w_last_cycle;
    logic                  w_timeout_pass;
    logic [NUM_HARTS-1:0]  w_reported;
    logic [NUM_HARTS-1:0]  w_passed;
    logic [XLEN-2:0]       w_testnum [NUM_HARTS];
    logic [HW-1:0]         w_fail_hart;
    logic [XLEN-2:0]       w_fail_testnum;

    assign w_run        = (r_state == ST_RUN);
    assign w_clear      = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last_cycle = (cycle_count == CW'(TIMEOUT_CYCLES - 1));

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        hart_result_latch #(
            .XLEN       (XLEN),
            .PASS_VALUE (PASS_VALUE)
        ) u_latch (
            .i_clk      (clk),
            .i_rst_n    (rst),
            .i_en       (w_run),
            .i_clear    (w_clear),
            .i_vld      (tohost_vld[h]),
            .i_data     (tohost_data[h*XLEN +: XLEN]),
            .o_reported (w_reported[h]),
            .o_passed   (w_passed[h]),
            .o_testnum  (w_testnum[h])
        );
    end

`ifdef TEST_SUPERVISOR_GP_FALLBACK_EN
    logic [NUM_HARTS-1:0] w_gp_ok;
    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_gp
        assign w_gp_ok[h] = (gp_value[h*XLEN +: XLEN] == PASS_VALUE);
    end
    assign w_timeout_pass = &(w_passed | (~w_reported & w_gp_ok));
`else
    logic w_gp_unused;
    assign w_gp_unused    = ^gp_value;
    assign w_timeout_pass = 1'b0;
`endif

    always_comb begin
        logic w_found;
        w_found        = 1'b0;
        w_fail_hart    = '0;
        w_fail_testnum = '0;
        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
            if (!w_found && w_reported[h] && !w_passed[h]) begin
                w_found        = 1'b1;
                w_fail_hart    = HW'(h);
                w_fail_testnum = w_testnum[h];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_rst_cnt    <= '0;
            core_rst     <= 1'b1;
            running      <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            fail_hart    <= '0;
            fail_testnum <= '0;
            cycle_count  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_RESET;
                        r_rst_cnt <= '0;
                    end
                end
                ST_RESET: begin
                    if (r_rst_cnt == RCW'(RESET_CYCLES - 1)) begin
                        r_state  <= ST_RUN;
                        core_rst <= 1'b0;
                        running  <= 1'b1;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cycle_count != CW'(TIMEOUT_CYCLES)) begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                    // A write completing the set on the timeout cycle wins over the timeout.
                    if (&w_reported || w_last_cycle) begin
                        r_state   <= ST_DONE;
                        core_rst  <= 1'b1;
                        running   <= 1'b0;
                        done      <= 1'b1;
                        fail_hart <= w_fail_hart;
                        if (&w_reported) begin
                            pass         <= &w_passed;
                            timeout      <= 1'b0;
                            fail_testnum <= w_fail_testnum;
                        end else begin
                            pass         <= w_timeout_pass;
                            timeout      <= 1'b1;
                            fail_testnum <= '0;
                        end
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        r_state      <= ST_RESET;
                        r_rst_cnt    <= '0;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        timeout      <= 1'b0;
                        fail_hart    <= '0;
                        fail_testnum <= '0;
                        cycle_count  <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_test_supervisor.sv
// Bench for test_supervisor: a 1-hart and a 2-hart (short timeout) instance checked
// every cycle against a behavioural model, plus hand-computed scenario checks.
module tb_test_supervisor;

    localparam int RC  = 2;
    localparam int TO1 = 5000;
    localparam int TO2 = 50;
`ifdef TEST_SUPERVISOR_GP_FALLBACK_EN
    localparam bit GP_EN = 1'b1;
`else
    localparam bit GP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        st1 = 1'b0;
    logic [0:0]  vld1 = '0;
    logic [31:0] data1 = '0;
    logic [31:0] gp1 = '0;
    logic        st2 = 1'b0;
    logic [1:0]  vld2 = '0;
    logic [63:0] data2 = '0;
    logic [63:0] gp2 = '0;

    logic        cr1, run1, dn1, ps1, to1;
    logic [0:0]  fh1;
    logic [30:0] ftn1;
    logic [12:0] cc1;
    logic        cr2, run2, dn2, ps2, to2;
    logic [0:0]  fh2;
    logic [30:0] ftn2;
    logic [5:0]  cc2;

    test_supervisor #(.NUM_HARTS(1), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO1)) dut1 (
        .clk(clk), .rst(rst), .start(st1), .core_rst(cr1), .tohost_vld(vld1),
        .tohost_data(data1), .gp_value(gp1), .running(run1), .done(dn1), .pass(ps1),
        .timeout(to1), .fail_hart(fh1), .fail_testnum(ftn1), .cycle_count(cc1));

    test_supervisor #(.NUM_HARTS(2), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO2)) dut2 (
        .clk(clk), .rst(rst), .start(st2), .core_rst(cr2), .tohost_vld(vld2),
        .tohost_data(data2), .gp_value(gp2), .running(run2), .done(dn2), .pass(ps2),
        .timeout(to2), .fail_hart(fh2), .fail_testnum(ftn2), .cycle_count(cc2));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: remaining reset cycles, run/done flags, elapsed run cycles and the
    // first qualifying report of each hart.
    bit          m_run [2];
    bit          m_done[2];
    bit          m_pass[2];
    bit          m_to  [2];
    int          m_rl  [2];
    int          m_cc  [2];
    int          m_fh  [2];
    logic [31:0] m_ftn [2];
    bit          m_rep [2][2];
    logic [31:0] m_val [2][2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_run[d] = 0; m_done[d] = 0; m_pass[d] = 0; m_to[d] = 0;
            m_rl[d] = 0; m_cc[d] = 0; m_fh[d] = 0; m_ftn[d] = '0;
            for (int h = 0; h < 2; h++) begin
                m_rep[d][h] = 0;
                m_val[d][h] = '0;
            end
        end
    endtask

    task automatic step(input int d, input logic s, input logic [1:0] v,
                        input logic [63:0] dat, input logic [63:0] gp);
        int nh, tmo, prev;
        bit all, ok, found;
        nh  = (d == 0) ? 1 : 2;
        tmo = (d == 0) ? TO1 : TO2;
        if (m_done[d]) begin
            if (s) begin
                m_done[d] = 0; m_pass[d] = 0; m_to[d] = 0; m_fh[d] = 0; m_ftn[d] = '0;
                m_cc[d] = 0; m_rl[d] = RC; m_rep[d][0] = 0; m_rep[d][1] = 0;
            end
        end else if (m_rl[d] > 0) begin
            m_rl[d]--;
            if (m_rl[d] == 0) m_run[d] = 1;
        end else if (m_run[d]) begin
            prev = m_cc[d];
            if (m_cc[d] < tmo) m_cc[d]++;
            all = 1; ok = 1; found = 0;
            for (int h = 0; h < nh; h++) begin
                if (v[h] && dat[h*32] && !m_rep[d][h]) begin
                    m_rep[d][h] = 1;
                    m_val[d][h] = dat[h*32 +: 32];
                end
                all = all && m_rep[d][h];
            end
            if (all || prev == tmo - 1) begin
                m_run[d] = 0; m_done[d] = 1; m_to[d] = !all;
                for (int h = 0; h < nh; h++) begin
                    if (m_rep[d][h]) begin
                        if (m_val[d][h] != 32'd1) begin
                            ok = 0;
                            if (!found) begin
                                found = 1;
                                m_fh[d] = h;
                                m_ftn[d] = all ? (m_val[d][h] >> 1) : 32'd0;
                            end
                        end
                    end else if (!(GP_EN && gp[h*32 +: 32] == 32'd1)) begin
                        ok = 0;
                    end
                end
                m_pass[d] = ok;
            end
        end else if (s) begin
            m_rl[d] = RC; m_rep[d][0] = 0; m_rep[d][1] = 0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                model_reset();
            end else begin
                step(0, st1, {1'b0, vld1}, {32'h0, data1}, {32'h0, gp1});
                step(1, st2, vld2, data2, gp2);
            end
        end
    end

    task automatic cmp(input int d, input logic cr, input logic rn, input logic dn,
                       input logic ps, input logic tmo, input logic [31:0] fh,
                       input logic [31:0] ftn, input logic [31:0] cc);
        chk($sformatf("d%0d_core_rst", d), cr, !m_run[d]);
        chk($sformatf("d%0d_running", d), rn, m_run[d]);
        chk($sformatf("d%0d_done", d), dn, m_done[d]);
        chk($sformatf("d%0d_pass", d), ps, m_pass[d]);
        chk($sformatf("d%0d_timeout", d), tmo, m_to[d]);
        chk($sformatf("d%0d_fail_hart", d), fh, m_fh[d]);
        chk($sformatf("d%0d_fail_testnum", d), ftn, m_ftn[d]);
        chk($sformatf("d%0d_cycle_count", d), cc, m_cc[d]);
    endtask

    always @(negedge clk) begin
        cmp(0, cr1, run1, dn1, ps1, to1, 32'(fh1), 32'(ftn1), 32'(cc1));
        cmp(1, cr2, run2, dn2, ps2, to2, 32'(fh2), 32'(ftn2), 32'(cc2));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        #2 rst = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(2);
        chk("reset_core_rst", cr1, 1'b1);
        chk("reset_done", dn1, 1'b0);

        // 1 hart: exactly RC core_rst cycles, start during RUN ignored, pass at cycle 100
        st1 = 1'b1; tick(1); st1 = 1'b0;
        n = 0;
        while (!run1 && n < 20) begin tick(1); n++; end
        chk("s1_reset_cycles", n, 2);
        chk("s1_core_rst_low", cr1, 1'b0);
        tick(50);
        st1 = 1'b1; tick(1); st1 = 1'b0;
        tick(49);
        vld1 = 1'b1; data1 = 32'h1; tick(1); vld1 = 1'b0;
        chk("s1_done", dn1, 1'b1);
        chk("s1_pass", ps1, 1'b1);
        chk("s1_timeout", to1, 1'b0);
        chk("s1_cycle_count", cc1, 101);

        // restart from DONE; data[0]=0 write ignored, then failing test 5
        st1 = 1'b1; tick(1); st1 = 1'b0;
        chk("s2_cleared_done", dn1, 1'b0);
        chk("s2_cleared_cc", cc1, 0);
        tick(2);
        chk("s2_running", run1, 1'b1);
        tick(1);
        vld1 = 1'b1; data1 = 32'h4; tick(1); vld1 = 1'b0;
        tick(1);
        vld1 = 1'b1; data1 = 32'hB; tick(1); vld1 = 1'b0;
        chk("s2_done", dn1, 1'b1);
        chk("s2_pass", ps1, 1'b0);
        chk("s2_fail_hart", fh1, 0);
        chk("s2_fail_testnum", ftn1, 5);
        chk("s2_cycle_count", cc1, 4);

        // 2 harts: only hart1 reports, timeout at 50
        gp2 = {32'h0, 32'h1};
        st2 = 1'b1; tick(1); st2 = 1'b0;
        tick(2);
        chk("s3_running", run2, 1'b1);
        tick(10);
        vld2 = 2'b10; data2 = {32'h1, 32'h0}; tick(1); vld2 = 2'b00;
        tick(5);
        vld2 = 2'b10; data2 = {32'h3, 32'h0}; tick(1); vld2 = 2'b00;
        n = 0;
        while (!dn2 && n < 100) begin tick(1); n++; end
        chk("s3_done", dn2, 1'b1);
        chk("s3_cycle_count", cc2, 50);
        chk("s3_timeout", to2, 1'b1);
        chk("s3_pass", ps2, GP_EN);
        chk("s3_fail_testnum", ftn2, 0);

        // hart0 fails (testnum 3); hart1 completes the set on the timeout cycle
        gp2 = '0;
        st2 = 1'b1; tick(1); st2 = 1'b0;
        tick(2);
        tick(5);
        vld2 = 2'b01; data2 = {32'h0, 32'h7}; tick(1); vld2 = 2'b00;
        tick(43);
        vld2 = 2'b10; data2 = {32'h1, 32'h0}; tick(1); vld2 = 2'b00;
        chk("s4_done", dn2, 1'b1);
        chk("s4_timeout", to2, 1'b0);
        chk("s4_pass", ps2, 1'b0);
        chk("s4_fail_hart", fh2, 0);
        chk("s4_fail_testnum", ftn2, 3);
        chk("s4_cycle_count", cc2, 50);

        // both harts pass at different cycles
        st2 = 1'b1; tick(1); st2 = 1'b0;
        tick(2);
        tick(3);
        vld2 = 2'b01; data2 = {32'h0, 32'h1}; tick(1); vld2 = 2'b00;
        tick(3);
        vld2 = 2'b10; data2 = {32'h1, 32'h0}; tick(1); vld2 = 2'b00;
        chk("s5_done", dn2, 1'b1);
        chk("s5_pass", ps2, 1'b1);
        chk("s5_timeout", to2, 1'b0);
        chk("s5_cycle_count", cc2, 8);

        // asynchronous reset mid-RUN
        st1 = 1'b1; tick(1); st1 = 1'b0;
        tick(2);
        chk("s6_running", run1, 1'b1);
        tick(10);
        #2 rst = 1'b0;
        #1;
        chk("s6_core_rst", cr1, 1'b1);
        chk("s6_running_low", run1, 1'b0);
        chk("s6_cycle_count", cc1, 0);
        chk("s6_d2_done_low", dn2, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        tick(1);
        st1 = 1'b1; tick(1); st1 = 1'b0;
        tick(2);
        chk("s7_running", run1, 1'b1);
        tick(2);
        vld1 = 1'b1; data1 = 32'h1; tick(1); vld1 = 1'b0;
        chk("s7_done", dn1, 1'b1);
        chk("s7_pass", ps1, 1'b1);
        chk("s7_cycle_count", cc1, 3);

        tick(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
